// File: rtl/fast_mem_pkg.sv
// fast_mem_pkg: shared types and default geometry for the frame memory read path
package fast_mem_pkg;

    localparam int DEF_ADDR_W     = 16;
    localparam int DEF_DATA_W     = 8;
    localparam int DEF_IMG_W      = 8;
    localparam int DEF_IMG_H      = 4;
    localparam int DEF_RD_LAT     = 1;
    localparam int DEF_FIFO_DEPTH = 4;

    // Coordinate width for a dimension of n pixels; a single-pixel dimension still needs one bit.
    function automatic int coord_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_X_W = coord_w(DEF_IMG_W);
    localparam int DEF_Y_W = coord_w(DEF_IMG_H);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        FIN
    } rd_state_t;

    // Pixel beat layout for the default frame geometry.
    typedef struct packed {
        logic [DEF_DATA_W-1:0] data;
        logic [DEF_X_W-1:0]    x;
        logic [DEF_Y_W-1:0]    y;
        logic                  last;
    } pix_beat_t;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy count; head reads as zero while empty
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic [W-1:0]           wdata_i,
    input  logic                   pop_i,
    output logic [W-1:0]           rdata_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   empty_o,
    output logic                   full_o
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push, do_pop;

    // A pop needs data; a push into a full FIFO is only taken alongside a pop.
    always_comb begin
        do_pop  = pop_i && cnt_q != '0;
        do_push = push_i && (cnt_q != CNT_W'(DEPTH) || do_pop);
        wr_d    = do_push ? wr_q + AW'(1) : wr_q;
        rd_d    = do_pop ? rd_q + AW'(1) : rd_q;
        cnt_d   = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    // Storage needs no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= wdata_i;
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    assign empty_o = cnt_q == '0;
    assign full_o  = cnt_q == CNT_W'(DEPTH);
    assign count_o = cnt_q;
    assign rdata_o = empty_o ? '0 : mem_q[rd_q];

endmodule

// File: rtl/frame_mem_reader.sv
// frame_mem_reader: raster-order frame fetch from synchronous memory into a valid/ready pixel stream
module frame_mem_reader
    import fast_mem_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int IMG_W      = DEF_IMG_W,
    parameter int IMG_H      = DEF_IMG_H,
    parameter int RD_LAT     = DEF_RD_LAT,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [ADDR_W-1:0]         base_addr,
    output logic                      busy,
    output logic                      done,
    output logic                      mem_re,
    output logic [ADDR_W-1:0]         mem_addr,
    input  logic [DATA_W-1:0]         mem_rdata,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_data,
    output logic [coord_w(IMG_W)-1:0] out_x,
    output logic [coord_w(IMG_H)-1:0] out_y,
    output logic                      out_last
);

    localparam int XW = coord_w(IMG_W);
    localparam int YW = coord_w(IMG_H);
    localparam int BW = DATA_W + XW + YW + 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [XW-1:0]     x;
        logic [YW-1:0]     y;
        logic              last;
    } beat_t;

    rd_state_t         state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [XW-1:0]     ix_q, ix_d;
    logic [YW-1:0]     iy_q, iy_d;
    logic [RD_LAT-1:0] vld_q;
    logic [XW-1:0]     px_q [RD_LAT];
    logic [YW-1:0]     py_q [RD_LAT];
    logic [RD_LAT-1:0] pl_q;
    logic [CW-1:0]     fifo_count, inflight, occupancy;
    logic              fifo_empty, fifo_full;
    logic              issue, pop, push, ix_end, iy_end;
    beat_t             head, push_beat;

    // Credit check: reads in flight plus buffered pixels, net of this cycle's pop, must leave a free slot.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) inflight = inflight + CW'(vld_q[i]);
        out_valid = !fifo_empty;
        pop       = out_valid && out_ready;
        occupancy = fifo_count + inflight - CW'(pop);
        issue     = state_q == ISSUE && occupancy < CW'(FIFO_DEPTH);
        ix_end    = ix_q == XW'(IMG_W - 1);
        iy_end    = iy_q == YW'(IMG_H - 1);
        push      = vld_q[RD_LAT-1];
        push_beat = {mem_rdata, px_q[RD_LAT-1], py_q[RD_LAT-1], pl_q[RD_LAT-1]};
        busy      = state_q == ISSUE || state_q == DRAIN;
        done      = state_q == FIN;
        mem_re    = issue;
        mem_addr  = issue ? addr_q : '0;
        out_data  = head.data;
        out_x     = head.x;
        out_y     = head.y;
        out_last  = head.last;
    end

    // Frame walk: the address runs alongside the raster counters, so no multiply is needed.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        ix_d    = ix_q;
        iy_d    = iy_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ISSUE;
                    addr_d  = base_addr;
                    ix_d    = '0;
                    iy_d    = '0;
                end
            end
            ISSUE: begin
                if (issue) begin
                    addr_d  = addr_q + ADDR_W'(1);
                    ix_d    = ix_end ? '0 : ix_q + XW'(1);
                    iy_d    = ix_end ? iy_q + YW'(1) : iy_q;
                    state_d = (ix_end && iy_end) ? DRAIN : ISSUE;
                end
            end
            DRAIN: state_d = (pop && head.last) ? FIN : DRAIN;
            FIN:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Control state and the read-valid pipe; reset drops any read still in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            ix_q    <= '0;
            iy_q    <= '0;
            vld_q   <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            ix_q     <= ix_d;
            iy_q     <= iy_d;
            vld_q[0] <= issue;
            for (int i = 1; i < RD_LAT; i++) vld_q[i] <= vld_q[i-1];
        end
    end

    // Coordinates travel with each read so the returning pixel knows where it sits.
    always_ff @(posedge clk) begin
        px_q[0] <= ix_q;
        py_q[0] <= iy_q;
        pl_q[0] <= ix_end && iy_end;
        for (int i = 1; i < RD_LAT; i++) begin
            px_q[i] <= px_q[i-1];
            py_q[i] <= py_q[i-1];
            pl_q[i] <= pl_q[i-1];
        end
    end

    sync_fifo #(
        .W     (BW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .wdata_i (push_beat),
        .pop_i   (pop),
        .rdata_o (head),
        .count_o (fifo_count),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    assert property (@(posedge clk) disable iff (rst) !(push && fifo_full && !pop));

endmodule

// File: tb/tb_frame_mem_reader.sv
// tb_frame_mem_reader: directed scenarios checked against a raster/credit model of the reader
module tb_frame_mem_reader;

    localparam int IMG_W      = 4;
    localparam int IMG_H      = 2;
    localparam int RD_LAT     = 1;
    localparam int FIFO_DEPTH = 4;
    localparam int NPIX       = IMG_W * IMG_H;

    logic        clk = 0;
    logic        rst = 1;
    logic        start = 0;
    logic        out_ready = 0;
    logic [15:0] base_addr = 16'h0000;
    logic        busy, done, mem_re, out_valid, out_last;
    logic [15:0] mem_addr;
    logic [7:0]  mem_rdata = 8'h00;
    logic [7:0]  out_data;
    logic [1:0]  out_x;
    logic [0:0]  out_y;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    frame_mem_reader #(
        .ADDR_W     (16),
        .DATA_W     (8),
        .IMG_W      (IMG_W),
        .IMG_H      (IMG_H),
        .RD_LAT     (RD_LAT),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .busy      (busy),
        .done      (done),
        .mem_re    (mem_re),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_x     (out_x),
        .out_y     (out_y),
        .out_last  (out_last)
    );

    // Synchronous memory whose contents equal the address low byte.
    always @(posedge clk) if (mem_re) mem_rdata <= mem_addr[7:0];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model state: frame progress expressed as counts of reads issued and pixels handed off.
    int          cyc = 0;
    logic        m_busy = 0;
    logic        m_done_exp = 0;
    logic [15:0] m_base = 16'h0000;
    int          n_iss = 0;
    int          n_pop = 0;
    int          iss_cyc [NPIX];
    int          acc_cyc = 0;
    int          first_lat = -1;
    logic        seen_valid = 0;
    int          dones = 0;
    int          avail;
    logic        pop_now, acc, credit;
    logic [7:0]  log_data[$];
    logic [1:0]  log_x[$];
    logic [0:0]  log_y[$];
    logic        log_last[$];
    logic [15:0] log_addr[$];
    int          log_cyc[$];

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            m_busy     = 0;
            m_done_exp = 0;
            n_iss      = 0;
            n_pop      = 0;
        end else begin
            acc     = start && !m_busy && !m_done_exp;
            pop_now = out_valid && out_ready;
            chk("done", done, m_done_exp);
            chk("busy", busy, m_busy);
            if (done) dones++;
            avail = 0;
            for (int i = 0; i < n_iss && i < NPIX; i++) if (iss_cyc[i] <= cyc - RD_LAT - 1) avail++;
            chk("out_valid", out_valid, avail > n_pop);
            if (out_valid && m_busy && !seen_valid) begin
                first_lat  = cyc - acc_cyc - 1;
                seen_valid = 1;
            end
            if (out_valid && n_pop < NPIX) begin
                chk("out_data", out_data, 32'(8'(m_base + 16'(n_pop))));
                chk("out_x", out_x, n_pop % IMG_W);
                chk("out_y", out_y, n_pop / IMG_W);
                chk("out_last", out_last, n_pop == NPIX - 1);
            end
            credit = m_busy && n_iss < NPIX && (n_iss - n_pop - int'(pop_now)) < FIFO_DEPTH;
            chk("mem_re", mem_re, credit);
            if (mem_re) begin
                chk("mem_addr", mem_addr, 32'(16'(m_base + 16'(n_iss))));
                log_addr.push_back(mem_addr);
                if (n_iss < NPIX) iss_cyc[n_iss] = cyc;
                n_iss++;
            end
            if (pop_now) begin
                log_data.push_back(out_data);
                log_x.push_back(out_x);
                log_y.push_back(out_y);
                log_last.push_back(out_last);
                log_cyc.push_back(cyc);
                n_pop++;
            end
            chk("outstanding_le_depth", n_iss - n_pop <= FIFO_DEPTH, 1);
            m_done_exp = pop_now && n_pop == NPIX;
            if (m_done_exp) m_busy = 0;
            if (acc) begin
                m_busy     = 1;
                m_base     = base_addr;
                n_iss      = 0;
                n_pop      = 0;
                acc_cyc    = cyc;
                seen_valid = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        log_data.delete();
        log_x.delete();
        log_y.delete();
        log_last.delete();
        log_addr.delete();
        log_cyc.delete();
    endtask

    task automatic do_start(input logic [15:0] b);
        base_addr = b;
        start     = 1;
        tick();
        start     = 0;
    endtask

    task automatic wait_done(input bit fin_start);
        logic got = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            tick();
            if (done) begin
                got = 1;
                if (fin_start) begin
                    base_addr = 16'h0500;
                    start     = 1;
                    tick();
                    start     = 0;
                end
            end
        end
        chk("done_seen", got, 1);
    endtask

    task automatic chk_zero(input string name);
        chk(name, {busy, done, mem_re, mem_addr, out_valid, out_data, out_x, out_y, out_last}, 0);
    endtask

    initial begin
        int   d0;
        logic got;
        repeat (3) tick();
        rst = 0;
        chk_zero("reset_outputs");

        // Free-running frame, then a start pulse in the done cycle that must be ignored.
        clear_logs();
        out_ready = 1;
        do_start(16'h0100);
        wait_done(1);
        repeat (3) tick();
        chk("fin_start_ignored", busy, 0);
        chk("s1_beats", log_data.size(), 8);
        chk("s1_first_data", log_data[0], 8'h00);
        chk("s1_first_xy", {log_x[0], log_y[0]}, 3'b00_0);
        chk("s1_last_data", log_data[7], 8'h07);
        chk("s1_last_xy", {log_x[7], log_y[7]}, 3'b11_1);
        chk("s1_last_flag", {log_last[6], log_last[7]}, 2'b01);
        chk("s1_consecutive", log_cyc[7] - log_cyc[0], 7);
        chk("s1_latency_edges", first_lat, 2);

        // Stalled consumer: credit caps reads at the buffer depth.
        clear_logs();
        out_ready = 0;
        do_start(16'h0100);
        repeat (10) tick();
        chk("stall_reads", log_addr.size(), 4);
        chk("stall_mem_re", mem_re, 0);
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, 8'h00);
        out_ready = 1;
        wait_done(0);
        chk("stall_beats", log_data.size(), 8);
        tick();

        // Random backpressure must not change the pixel sequence.
        void'($urandom(32'd2024));
        clear_logs();
        out_ready = 0;
        do_start(16'h0100);
        got = 0;
        for (int i = 0; i < 300 && !got; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            tick();
            if (done) got = 1;
        end
        chk("rand_done_seen", got, 1);
        chk("rand_beats", log_data.size(), 8);
        for (int i = 0; i < log_data.size(); i++) begin
            chk("rand_data", log_data[i], i);
            chk("rand_xy", {log_x[i], log_y[i]}, {2'(i % IMG_W), 1'(i / IMG_W)});
        end
        out_ready = 1;
        tick();

        // Mid-frame reset after the third beat, then a clean frame from a new base.
        clear_logs();
        do_start(16'h0100);
        for (int i = 0; i < 50 && log_data.size() < 3; i++) tick();
        chk("pre_reset_beats", log_data.size(), 3);
        d0  = dones;
        rst = 1;
        tick();
        rst = 0;
        chk_zero("midreset_outputs");
        repeat (6) tick();
        chk("midreset_no_done", dones - d0, 0);
        clear_logs();
        do_start(16'h0200);
        wait_done(0);
        chk("post_reset_beats", log_data.size(), 8);
        chk("post_reset_first", log_data[0], 8'h00);
        chk("post_reset_last", log_data[7], 8'h07);
        tick();

        // Start pulses while busy are ignored.
        clear_logs();
        d0 = dones;
        do_start(16'h0100);
        tick();
        base_addr = 16'h0300;
        start     = 1;
        tick();
        start     = 0;
        tick();
        tick();
        start     = 1;
        tick();
        start     = 0;
        wait_done(0);
        repeat (5) tick();
        chk("busy_start_beats", log_data.size(), 8);
        chk("busy_start_dones", dones - d0, 1);

        // Address wrap at the top of memory.
        clear_logs();
        do_start(16'hFFFC);
        wait_done(0);
        tick();
        chk("wrap_addr0", log_addr[0], 16'hFFFC);
        chk("wrap_addr3", log_addr[3], 16'hFFFF);
        chk("wrap_addr4", log_addr[4], 16'h0000);
        chk("wrap_addr7", log_addr[7], 16'h0003);
        chk("wrap_data3", log_data[3], 8'hFF);
        chk("wrap_data4", log_data[4], 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/frame_mem_reader.md
Name: frame_mem_reader

Overview:
- Reader-side counterpart to the pixel memory write path.
- On `start`, walks a rectangular frame stored in synchronous-read pixel memory in raster order and issues one read per pixel.
- Absorbs the fixed memory read latency and presents pixels as a valid/ready stream, with coordinates, to the downstream FAST window builder.
- Backpressure never drops or duplicates a pixel.

Parameters:
- ADDR_W, 16, memory address width.
- DATA_W, 8, pixel width.
- IMG_W, 8, frame width in pixels (>=2).
- IMG_H, 4, frame height in pixels (>=1).
- RD_LAT, 1, memory read latency in cycles (1 or 2).
- FIFO_DEPTH, 4, output buffer entries (>= RD_LAT+2, power of 2).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begin frame read; ignored unless idle.
- base_addr  in  ADDR_W  frame start address, sampled on accepted start.
- busy  out  1  high from accepted start until last pixel is handed off.
- done  out  1  one-cycle pulse, the cycle after the last pixel handshake.
- mem_re  out  1  read enable to memory.
- mem_addr  out  ADDR_W  read address, valid with mem_re.
- mem_rdata  in  DATA_W  read data, valid exactly RD_LAT cycles after mem_re.
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready from consumer.
- out_data  out  DATA_W  pixel value.
- out_x  out  $clog2(IMG_W)  column of out_data.
- out_y  out  $clog2(IMG_H)  row of out_data.
- out_last  out  1  high with the final pixel (IMG_W-1, IMG_H-1).

Behaviour:
- Reset values:
  - On rst=1 at a clock edge, all outputs go to 0: busy, done, mem_re, mem_addr, out_valid, out_data, out_x, out_y, out_last.
  - FIFO is emptied, in-flight count cleared, FSM returns to IDLE.
  - Reset mid-frame aborts the frame. Read data returning after reset is discarded; no done is generated.
- FSM states:
  - IDLE: busy=0. start=1 -> latch base_addr, clear issue counters (ix=0, iy=0) -> ISSUE.
  - ISSUE: busy=1. Issue a read whenever credit is available (see below): mem_re=1, mem_addr=base_addr+iy*IMG_W+ix. Advance ix; on wrap advance iy. When the read for (IMG_W-1, IMG_H-1) issues -> DRAIN.
  - DRAIN: no reads. Wait until in-flight count and FIFO are both empty -> FIN.
  - FIN: done=1 for one cycle, busy=0 -> IDLE.
- Address arithmetic:
  - Compute incrementally with a running address register, not a multiplier.
  - Wraps modulo 2^ADDR_W; no overflow flag.
- Credit rule:
  - A read issues in a cycle only if (fifo_count + inflight) < FIFO_DEPTH.
  - fifo_count includes a pop occurring in the same cycle; a simultaneous pop frees the credit in that cycle.
  - Guarantees returning data always has a FIFO slot. The memory is never stalled; mem_rdata is captured unconditionally RD_LAT cycles after mem_re.
- Read tracking:
  - mem_re is delayed through an RD_LAT-stage valid pipe, alongside a coordinate pipe (x, y, last).
  - At pipe exit, {data, x, y, last} is pushed into the FIFO.
- Output stream:
  - out_valid = FIFO not empty. Fields come from the FIFO head, registered at the head entry.
  - Handshake on out_valid & out_ready pops the head.
  - While out_valid=1 and out_ready=0, out_data/x/y/last hold stable.
  - Push and pop in the same cycle keep the count unchanged.
- Throughput: with out_ready held high, one pixel per cycle sustained.
- Latency: first out_valid appears RD_LAT+1 cycles after the accepted start cycle.
- Ordering: strict raster order (x fastest).
- Boundary cases:
  - start while busy is ignored.
  - start in the FIN cycle is ignored.
  - IMG_H=1: a single row with out_last on x=IMG_W-1.

Decomposition:
- Package fast_mem_pkg holds:
  - struct pix_beat_t {data, x, y, last};
  - the state enum rd_state_t {IDLE, ISSUE, DRAIN, FIN};
  - localparams for the coordinate widths.
- One sub-module: sync_fifo (parameterised width and depth, synchronous active-high reset, push/pop/count/empty/full).
- The pipe and FSM stay in frame_mem_reader.

Test Plan:
All scenarios use IMG_W=4, IMG_H=2, RD_LAT=1, FIFO_DEPTH=4, and a memory model whose data = address low byte.
1. Free-running: base_addr=0x0100, start, out_ready=1 -> 8 beats on consecutive cycles, data 0x00..0x07, (x,y) = (0,0)..(3,1), out_last only on beat 8, done one cycle after beat 8, busy low with done.
2. Backpressure: out_ready=0 for 10 cycles after start -> exactly 4 reads issued, then mem_re=0. out_valid held with data 0x00 stable. Releasing ready yields all 8 pixels, in order, none duplicated.
3. Random out_ready (50%, seeded) -> the output sequence is identical to scenario 1. Scoreboard: inflight+fifo_count never exceeds 4.
4. Mid-frame reset: assert rst after beat 3 -> next cycle all outputs 0 and no done. A fresh start with base_addr=0x0200 yields data 0x00..0x07 correctly.
5. start pulses while busy (at cycles 2 and 5) -> ignored; exactly 8 beats and one done.
6. Address wrap: base_addr=0xFFFC -> addresses 0xFFFC..0xFFFF, then 0x0000..0x0003; data 0xFC..0xFF, 0x00..0x03.
